// File: rtl/local_car_detector_if.sv
// Signal bundle between the loop conditioner and its environment.
// Carries the raw loop input and the request/presence/cap-out/arrival outputs.
interface local_car_detector_if #(
    parameter int CNT_W = 8
);
    logic             loop_raw;
    logic             X;
    logic             present;
    logic             max_out;
    logic [CNT_W-1:0] arrivals;

    modport master (output loop_raw, input X, present, max_out, arrivals);
    modport slave  (input loop_raw, output X, present, max_out, arrivals);
endinterface

// File: rtl/local_car_detector.sv
// Conditions the raw local-road loop into the registered car request X for the light FSM.
// Latency: loop_raw->present 2+DEB_CYC edges, present->X 1 edge; no backpressure, outputs are levels.
module local_car_detector #(
    parameter int DEB_CYC     = 4,
    parameter int GAP_CYC     = 6,
    parameter int MAX_HOLD    = 32,
    parameter int LOCKOUT_CYC = 8,
    parameter int CNT_W       = 8
) (
    input  logic                 clk,
    input  logic                 clr_n,
    local_car_detector_if.slave  bus
);
    localparam int DEB_W  = $clog2(DEB_CYC + 1);
    localparam int GAP_W  = $clog2(GAP_CYC + 1);
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam int LOCK_W = $clog2(LOCKOUT_CYC + 1);

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYC - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYC - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCKOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        GAP     = 2'd2,
        LOCKOUT = 2'd3
    } state_t;

    logic              sync1_q, sync2_q;
    logic              present_q, present_d;
    logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic [CNT_W-1:0]  arrivals_q, arrivals_d;
    state_t            state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
    logic              x_q, x_d;
    logic              max_out_q, max_out_d;

    // A level change must persist for DEB_CYC consecutive cycles before present follows.
    always_comb begin
        present_d  = present_q;
        deb_cnt_d  = '0;
        arrivals_d = arrivals_q;
        if (sync2_q != present_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                present_d = ~present_q;
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
        end
        if (present_d && !present_q && (arrivals_q != '1)) begin
            arrivals_d = arrivals_q + CNT_W'(1);
        end
    end

    // Counters default to clear so each state entry starts from zero.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = '0;
        gap_cnt_d  = '0;
        lock_cnt_d = '0;
        max_out_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (present_q) state_d = REQ;
            end
            REQ: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d   = LOCKOUT;
                    max_out_d = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    if (!present_q) state_d = GAP;
                end
            end
            GAP: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d   = LOCKOUT;
                    max_out_d = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    if (present_q) begin
                        state_d = REQ;
                    end else if (gap_cnt_q == GAP_LAST) begin
                        state_d = IDLE;
                    end else begin
                        gap_cnt_d = gap_cnt_q + GAP_W'(1);
                    end
                end
            end
            LOCKOUT: begin
                if (lock_cnt_q == LOCK_LAST) begin
                    state_d = present_q ? REQ : IDLE;
                end else begin
                    lock_cnt_d = lock_cnt_q + LOCK_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        x_d = (state_d == REQ) || (state_d == GAP);
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            present_q  <= 1'b0;
            deb_cnt_q  <= '0;
            arrivals_q <= '0;
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            gap_cnt_q  <= '0;
            lock_cnt_q <= '0;
            x_q        <= 1'b0;
            max_out_q  <= 1'b0;
        end else begin
            sync1_q    <= bus.loop_raw;
            sync2_q    <= sync1_q;
            present_q  <= present_d;
            deb_cnt_q  <= deb_cnt_d;
            arrivals_q <= arrivals_d;
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            lock_cnt_q <= lock_cnt_d;
            x_q        <= x_d;
            max_out_q  <= max_out_d;
        end
    end

    assign bus.X        = x_q;
    assign bus.present  = present_q;
    assign bus.max_out  = max_out_q;
    assign bus.arrivals = arrivals_q;
endmodule

// File: tb/tb_local_car_detector.sv
// Bench for local_car_detector: directed spec scenarios plus random loop traffic,
// every cycle compared against a behavioural model of presence, request and arrivals.
module tb_local_car_detector;
    localparam int DEB  = 4;
    localparam int GAP  = 6;
    localparam int MAXH = 32;
    localparam int LOCK = 8;

    logic clk = 1'b0;
    logic clr_n;
    always #5 clk = ~clk;

    local_car_detector_if #(.CNT_W(8)) bus ();

    local_car_detector #(
        .DEB_CYC(DEB), .GAP_CYC(GAP), .MAX_HOLD(MAXH), .LOCKOUT_CYC(LOCK), .CNT_W(8)
    ) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Model: run length of a differing level, request held/absent/lockout-remaining counts.
    bit m_s1, m_s2, m_present, m_req, m_max;
    int m_run, m_arr, m_held, m_absent, m_lock_left;

    always @(posedge clk) begin : model
        bit old_p;
        if (!clr_n) begin
            m_s1 = 0; m_s2 = 0; m_present = 0; m_req = 0; m_max = 0;
            m_run = 0; m_arr = 0; m_held = 0; m_absent = 0; m_lock_left = 0;
        end else begin
            old_p = m_present;
            if (m_s2 != m_present) begin
                m_run++;
                if (m_run == DEB) begin
                    m_present = !m_present;
                    m_run = 0;
                    if (m_present && m_arr < 255) m_arr++;
                end
            end else begin
                m_run = 0;
            end
            m_s2 = m_s1;
            m_s1 = bus.loop_raw;
            m_max = 0;
            if (m_lock_left > 0) begin
                m_lock_left--;
                if (m_lock_left == 0 && old_p) begin
                    m_req = 1; m_held = 1; m_absent = 0;
                end
            end else if (m_req) begin
                if (m_held == MAXH) begin
                    m_req = 0; m_max = 1; m_lock_left = LOCK;
                end else begin
                    if (old_p) m_absent = 0;
                    else m_absent++;
                    if (m_absent > GAP) m_req = 0;
                    else m_held++;
                end
            end else if (old_p) begin
                m_req = 1; m_held = 1; m_absent = 0;
            end
        end
    end

    function automatic logic [10:0] exp_vec();
        return {m_req, m_present, m_max, 8'(m_arr)};
    endfunction

    logic [10:0] dut_vec;
    assign dut_vec = {bus.X, bus.present, bus.max_out, bus.arrivals};

    task automatic cyc(input bit v);
        bus.loop_raw = v;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        clr_n = 1'b0;
        cyc(0);
        cyc(0);
        clr_n = 1'b1;
    endtask

    task automatic test_reset();
        clr_n = 1'b0;
        cyc(0);
        cyc(0);
        checks++;
        if (dut_vec !== 11'd0) begin
            failures++;
            $display("FAIL reset_state {X,present,max_out,arrivals}: got %h expected %h", dut_vec, 11'd0);
        end
        clr_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc(0);
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL reset_idle cyc=%0d: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_assert();
        int ep = 0;
        int ex = 0;
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            cyc(1);
            if (bus.present && ep == 0) ep = k;
            if (bus.X && ex == 0) ex = k;
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL assert cyc=%0d: got %h expected %h", k, dut_vec, exp_vec());
            end
        end
        checks++;
        if (ep != 2 + DEB) begin
            failures++;
            $display("FAIL assert_present_latency: got %0d expected %0d", ep, 2 + DEB);
        end
        checks++;
        if (ex != 3 + DEB) begin
            failures++;
            $display("FAIL assert_x_latency: got %0d expected %0d", ex, 3 + DEB);
        end
        checks++;
        if (bus.arrivals !== 8'd1) begin
            failures++;
            $display("FAIL assert_arrivals: got %0d expected 1", bus.arrivals);
        end
    endtask

    task automatic test_glitch();
        bit v;
        do_reset();
        for (int i = 0; i < 24; i++) begin
            v = (i < 3) ? 1'b1 : ((i < 6) ? 1'b0 : bit'(i % 2));
            cyc(v);
            checks++;
            if (dut_vec !== 11'd0 || dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL glitch cyc=%0d: got %h expected %h", i, dut_vec, 11'd0);
            end
        end
    endtask

    task automatic test_departure();
        int pf = 0;
        int xf = 0;
        do_reset();
        for (int k = 1; k <= 45; k++) begin
            cyc(k <= 12);
            if (k > 12 && !bus.present && pf == 0) pf = k;
            if (k > 12 && !bus.X && xf == 0) xf = k;
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL departure cyc=%0d: got %h expected %h", k, dut_vec, exp_vec());
            end
        end
        checks++;
        if (pf == 0 || xf - pf != GAP + 1) begin
            failures++;
            $display("FAIL departure_hold: got %0d edges expected %0d", xf - pf, GAP + 1);
        end
    endtask

    task automatic test_gap_boundary();
        int lens[3] = '{4, 6, 7};
        int want_drop[3] = '{0, 0, 1};
        int drops;
        int plow;
        bit seen_x;
        for (int t = 0; t < 3; t++) begin
            do_reset();
            drops = 0; plow = 0; seen_x = 0;
            for (int k = 1; k <= 10 + lens[t] + 12; k++) begin
                cyc(!(k > 10 && k <= 10 + lens[t]));
                if (bus.X) seen_x = 1;
                else if (seen_x) drops++;
                if (k > 10 && !bus.present) plow++;
                checks++;
                if (dut_vec !== exp_vec()) begin
                    failures++;
                    $display("FAIL gap%0d cyc=%0d: got %h expected %h", lens[t], k, dut_vec, exp_vec());
                end
            end
            checks++;
            if (drops != want_drop[t] || plow != lens[t] || bus.arrivals !== 8'd2) begin
                failures++;
                $display("FAIL gap%0d_summary: x_low=%0d present_low=%0d arrivals=%0d expected %0d %0d 2",
                         lens[t], drops, plow, bus.arrivals, want_drop[t], lens[t]);
            end
        end
    endtask

    task automatic test_capout();
        bit xs[1:100];
        bit ms[1:100];
        int phase = 0;
        int r1 = 0;
        int r0 = 0;
        int first_low = 0;
        int pulses = 0;
        bit pulse_ok;
        do_reset();
        for (int k = 1; k <= 100; k++) begin
            cyc(1);
            xs[k] = bus.X;
            ms[k] = bus.max_out;
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL capout cyc=%0d: got %h expected %h", k, dut_vec, exp_vec());
            end
        end
        for (int k = 1; k <= 100; k++) begin
            pulses += int'(ms[k]);
            case (phase)
                0: if (xs[k]) begin phase = 1; r1 = 1; end
                1: if (xs[k]) r1++; else begin phase = 2; r0 = 1; first_low = k; end
                2: if (!xs[k]) r0++; else phase = 3;
                default: ;
            endcase
        end
        pulse_ok = (first_low > 0 && first_low < 100) ? (ms[first_low] && !ms[first_low + 1]) : 1'b0;
        checks++;
        if (r1 != MAXH || r0 != LOCK) begin
            failures++;
            $display("FAIL capout_runs: high=%0d low=%0d expected %0d %0d", r1, r0, MAXH, LOCK);
        end
        checks++;
        if (pulse_ok !== 1'b1 || pulses != 2) begin
            failures++;
            $display("FAIL capout_max_out: single=%0d pulses=%0d expected 1 2", pulse_ok, pulses);
        end
        checks++;
        if (bus.arrivals !== 8'd1) begin
            failures++;
            $display("FAIL capout_arrivals: got %0d expected 1", bus.arrivals);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k < 10; k++) cyc(1);
        checks++;
        if (bus.X !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset_pre: X got %b expected 1", bus.X);
        end
        clr_n = 1'b0;
        cyc(1);
        checks++;
        if (bus.X !== 1'b0 || bus.arrivals !== 8'd0) begin
            failures++;
            $display("FAIL mid_reset: X=%b arrivals=%0d expected 0 0", bus.X, bus.arrivals);
        end
        clr_n = 1'b1;
    endtask

    task automatic test_saturation();
        int prev = 0;
        bit wrapped = 0;
        do_reset();
        for (int a = 0; a < 262; a++) begin
            for (int k = 0; k < 10; k++) begin
                cyc(k < 5);
                if (int'(bus.arrivals) < prev) wrapped = 1;
                prev = int'(bus.arrivals);
                checks++;
                if (dut_vec !== exp_vec()) begin
                    failures++;
                    $display("FAIL saturation a=%0d: got %h expected %h", a, dut_vec, exp_vec());
                end
            end
        end
        checks++;
        if (bus.arrivals !== 8'd255 || wrapped !== 1'b0) begin
            failures++;
            $display("FAIL saturation_final: arrivals=%0d wrapped=%0d expected 255 0", bus.arrivals, wrapped);
        end
    endtask

    task automatic test_random();
        int left = 0;
        bit lvl = 0;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if (left == 0) begin
                lvl = !lvl;
                left = $urandom_range(1, 12);
            end
            left--;
            clr_n = ($urandom_range(0, 599) != 0);
            cyc(lvl);
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL random cyc=%0d: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
        clr_n = 1'b1;
    endtask

    initial begin
        clr_n = 1'b0;
        bus.loop_raw = 1'b0;
        @(negedge clk);
        test_reset();
        test_assert();
        test_glitch();
        test_departure();
        test_gap_boundary();
        test_capout();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
